// File: rtl/mm_xfer_pkg.sv
// Shared types and widths for the matrix-multiply host transfer block.
//   xfer_state_t : job sequencing states
//   ELEM_W/OPND_W: operand element and packed operand word widths
//   RES_W/RES_ELEM_W: result word and streamed result element widths
package mm_xfer_pkg;

    localparam int ELEM_W     = 16;
    localparam int OPND_W     = 64;
    localparam int RES_W      = 128;
    localparam int RES_ELEM_W = 32;

    localparam int ELEMS_PER_OPND = OPND_W / ELEM_W;
    localparam int BEATS_PER_RES  = RES_W / RES_ELEM_W;
    localparam int OPND_LANE_W    = $clog2(ELEMS_PER_OPND);
    localparam int RES_LANE_W     = $clog2(BEATS_PER_RES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        RUN,
        RD,
        DRAIN
    } xfer_state_t;

endpackage

// File: rtl/mm_res_unpack.sv
// Result word serializer: captures one 128-bit result word and hands it out
// as four 32-bit beats, lane [31:0] first, with valid/ready flow control.
// Ports:
//   clk, n_rst    : clock, synchronous active-low reset
//   load          : capture word (only issued while the serializer is empty)
//   load_last     : captured word is the final word of the job
//   word          : result word to serialize
//   data, valid   : current beat, held stable until ready
//   ready         : downstream accept
//   last          : current beat is the final beat of the job
//   word_done     : fourth beat of the current word is being accepted
module mm_res_unpack
    import mm_xfer_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic                  load_last,
    input  logic [RES_W-1:0]      word,
    output logic [RES_ELEM_W-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  last,
    output logic                  word_done
);

    localparam logic [RES_LANE_W-1:0] LANE_LAST = RES_LANE_W'(BEATS_PER_RES - 1);
    localparam logic [RES_LANE_W-1:0] LANE_ONE  = RES_LANE_W'(1);

    logic [BEATS_PER_RES-1:0][RES_ELEM_W-1:0] word_q;
    logic [RES_LANE_W-1:0]                    lane_q;
    logic                                     last_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            word_q <= '0;
            lane_q <= '0;
            last_q <= 1'b0;
            valid  <= 1'b0;
        end else if (load) begin
            word_q <= word;
            lane_q <= '0;
            last_q <= load_last;
            valid  <= 1'b1;
        end else if (valid && ready) begin
            lane_q <= lane_q + LANE_ONE;
            if (lane_q == LANE_LAST) begin
                valid <= 1'b0;
            end
        end
    end

    assign data      = word_q[lane_q];
    assign word_done = valid && ready && (lane_q == LANE_LAST);
    assign last      = valid && last_q && (lane_q == LANE_LAST);

endmodule

// File: rtl/mm_host_xfer.sv
// Host-side transfer engine for the matrix-multiply unit. Packs a 16-bit
// operand stream into 64-bit words written to the operand buffer, holds the
// unit's active-low run enable for RUN_CYCLES, then reads 128-bit result
// words back and streams them out as 32-bit beats.
// Ports:
//   clk, n_rst                         : clock, synchronous active-low reset
//   s_data/s_valid/s_ready/s_last      : operand element stream in
//   opnd_we/opnd_addr/opnd_wdata       : operand memory write port
//   mm_enable                          : MM unit run enable (0 = run)
//   res_addr/res_rdata                 : result memory read port (1-cycle latency)
//   m_data/m_valid/m_ready/m_last      : result element stream out
//   done                               : 1-cycle pulse after the final beat is accepted
//   err_overrun                        : sticky, operand buffer filled without s_last
//   perf_cycles                        : job cycle count (only with MM_HOST_XFER_PERF_EN)
// Optional feature macro: MM_HOST_XFER_PERF_EN
module mm_host_xfer
    import mm_xfer_pkg::*;
#(
    parameter int unsigned OPND_WORDS  = 8,
    parameter int unsigned OPND_BASE   = 0,
    parameter int unsigned OPND_STRIDE = 2,
    parameter int unsigned RES_WORDS   = 4,
    parameter int unsigned RES_BASE    = 16,
    parameter int unsigned RES_STRIDE  = 4,
    parameter int unsigned RUN_CYCLES  = 24
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [ELEM_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic                  opnd_we,
    output logic [7:0]            opnd_addr,
    output logic [OPND_W-1:0]     opnd_wdata,
    output logic                  mm_enable,
    output logic [7:0]            res_addr,
    input  logic [RES_W-1:0]      res_rdata,
    output logic [RES_ELEM_W-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  done,
    output logic                  err_overrun
`ifdef MM_HOST_XFER_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int RUN_W = $clog2(RUN_CYCLES + 1);
    localparam logic [OPND_LANE_W-1:0] ELEM_LAST = OPND_LANE_W'(ELEMS_PER_OPND - 1);
    localparam logic [OPND_LANE_W-1:0] ELEM_ONE  = OPND_LANE_W'(1);

    xfer_state_t state, state_nx;

    logic [ELEMS_PER_OPND-1:0][ELEM_W-1:0] pack_q, pack_nx;
    logic [OPND_LANE_W-1:0] elem_q;
    logic [7:0]             wcnt_q;
    logic [7:0]             wr_addr_q;
    logic [7:0]             rd_addr_q;
    logic [7:0]             rd_idx_q;
    logic [RUN_W-1:0]       run_cnt_q;
    logic                   we_q;
    logic [OPND_W-1:0]      wdata_q;
    logic                   rd_pend_q;
    logic                   done_q;
    logic                   err_q;

    logic accept, close_word, last_word, last_rd;
    logic unpack_load, word_done;

    assign s_ready    = n_rst && ((state == IDLE) || (state == LOAD));
    assign accept     = s_valid && s_ready;
    assign close_word = accept && ((elem_q == ELEM_LAST) || s_last);
    assign last_word  = (wcnt_q == 8'(OPND_WORDS - 1));
    assign last_rd    = (rd_idx_q == 8'(RES_WORDS - 1));
    // The read issued in RD returns during the first DRAIN cycle.
    assign unpack_load = (state == DRAIN) && rd_pend_q;

    always_comb begin
        pack_nx         = pack_q;
        pack_nx[elem_q] = s_data;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (close_word && (s_last || last_word)) ? PAD : LOAD;
                end
            end
            LOAD: begin
                if (close_word && (s_last || last_word)) begin
                    state_nx = PAD;
                end
            end
            // PAD also covers the cycle in which the final word is on the bus,
            // so RUN always starts right after the last write.
            PAD: begin
                if (wcnt_q == 8'(OPND_WORDS)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
                    state_nx = RD;
                end
            end
            RD: begin
                state_nx = DRAIN;
            end
            DRAIN: begin
                if (word_done) begin
                    state_nx = last_rd ? IDLE : RD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            pack_q    <= '0;
            elem_q    <= '0;
            wcnt_q    <= '0;
            wr_addr_q <= 8'(OPND_BASE);
            rd_addr_q <= 8'(RES_BASE);
            rd_idx_q  <= '0;
            run_cnt_q <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            rd_pend_q <= (state == RD);

            if (we_q) begin
                wr_addr_q <= wr_addr_q + 8'(OPND_STRIDE);
            end

            if (accept) begin
                if (close_word) begin
                    we_q    <= 1'b1;
                    wdata_q <= pack_nx;
                    pack_q  <= '0;
                    elem_q  <= '0;
                    wcnt_q  <= wcnt_q + 8'd1;
                    if (last_word && !s_last) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    pack_q <= pack_nx;
                    elem_q <= elem_q + ELEM_ONE;
                end
            end

            if ((state == PAD) && (wcnt_q != 8'(OPND_WORDS))) begin
                we_q    <= 1'b1;
                wdata_q <= '0;
                wcnt_q  <= wcnt_q + 8'd1;
            end

            run_cnt_q <= (state == RUN) ? run_cnt_q + RUN_W'(1) : '0;

            if ((state == DRAIN) && word_done) begin
                if (last_rd) begin
                    done_q    <= 1'b1;
                    rd_idx_q  <= '0;
                    rd_addr_q <= 8'(RES_BASE);
                    wr_addr_q <= 8'(OPND_BASE);
                    wcnt_q    <= '0;
                end else begin
                    rd_idx_q  <= rd_idx_q + 8'd1;
                    rd_addr_q <= rd_addr_q + 8'(RES_STRIDE);
                end
            end
        end
    end

    mm_res_unpack u_unpack (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (unpack_load),
        .load_last (last_rd),
        .word      (res_rdata),
        .data      (m_data),
        .valid     (m_valid),
        .ready     (m_ready),
        .last      (m_last),
        .word_done (word_done)
    );

    assign opnd_we     = we_q;
    assign opnd_addr   = wr_addr_q;
    assign opnd_wdata  = wdata_q;
    assign mm_enable   = (state != RUN);
    assign res_addr    = rd_addr_q;
    assign done        = done_q;
    assign err_overrun = err_q;

`ifdef MM_HOST_XFER_PERF_EN
    logic [31:0] perf_q;
    logic        perf_run_q;

    // Accept cycle counts as 1; the done cycle is included before stopping.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            perf_q     <= '0;
            perf_run_q <= 1'b0;
        end else if (accept && (state == IDLE)) begin
            perf_q     <= 32'd1;
            perf_run_q <= 1'b1;
        end else if (perf_run_q) begin
            if (perf_q != '1) begin
                perf_q <= perf_q + 32'd1;
            end
            if (done_q) begin
                perf_run_q <= 1'b0;
            end
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
